// File: rtl/control_unit.sv
// control_unit
// Multicycle control FSM for cpu_unit. Sequences fetch, decode, execute,
// memory and writeback, and raises the bad-opcode and overflow exceptions.
// Every control output is registered from the next state. The one exception
// is the BRANCH term of PC_w, which must follow the ALU zero flag in the
// same cycle.

module control_unit #(
   parameter int MEM_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       overflow,
   output logic       PC_w,
   output logic [1:0] pc_src,
   output logic [1:0] crtl_error,
   output logic [1:0] crtl_iord,
   output logic [1:0] crtl_ss,
   output logic       crtl_mem_w,
   output logic       crtl_irwrite,
   output logic [2:0] crtl_regdst,
   output logic [3:0] crtl_memtoreg,
   output logic       reg_w,
   output logic       ab_w,
   output logic       aluout_w,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic       epc_w,
   output logic [4:0] state
);

   typedef enum logic [4:0] {
      S_RESET  = 5'd0,
      S_FETCH  = 5'd1,
      S_FWAIT  = 5'd2,
      S_IRLD   = 5'd3,
      S_DECODE = 5'd4,
      S_RX     = 5'd5,
      S_WBR    = 5'd6,
      S_ADDI   = 5'd7,
      S_WBI    = 5'd8,
      S_BRANCH = 5'd9,
      S_MADDR  = 5'd10,
      S_MRD    = 5'd11,
      S_MWAIT  = 5'd12,
      S_WBL    = 5'd13,
      S_MWR    = 5'd14,
      S_LUI    = 5'd15,
      S_JUMP   = 5'd16,
      S_JAL    = 5'd17,
      S_JR     = 5'd18,
      S_EXC    = 5'd19,
      S_EWAIT  = 5'd20,
      S_ELD    = 5'd21
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;

   localparam logic [2:0] ALU_PASS = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;
   localparam logic [2:0] ALU_AND  = 3'd3;

   localparam logic [1:0] CAUSE_OPCODE   = 2'd0;
   localparam logic [1:0] CAUSE_OVERFLOW = 2'd1;

   // A wait state lasts MEM_LAT cycles: load MEM_LAT-1 on entry, leave at 0.
   localparam logic [1:0] WAIT_LOAD = 2'(MEM_LAT - 1);

   state_t     cur_state;
   state_t     next_state;
   logic [1:0] wait_cnt;
   logic [1:0] cause;
   logic [1:0] next_cause;
   logic       pc_w_q;
   logic       branch_taken;
   logic       entering_wait;

   // Next-state and exception-cause selection from the current state and inputs.
   always_comb begin
      next_state = cur_state;
      next_cause = cause;
      case (cur_state)
         S_RESET:  next_state = S_FETCH;
         S_FETCH:  next_state = S_FWAIT;
         S_FWAIT:  if (wait_cnt == 2'd0) next_state = S_IRLD;
         S_IRLD:   next_state = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE: begin
                  if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND) begin
                     next_state = S_RX;
                  end else if (funct == FN_JR) begin
                     next_state = S_JR;
                  end else begin
                     next_state = S_EXC;
                     next_cause = CAUSE_OPCODE;
                  end
               end
               OP_ADDI:                   next_state = S_ADDI;
               OP_BEQ, OP_BNE:            next_state = S_BRANCH;
               OP_LW, OP_SW, OP_SB, OP_SH: next_state = S_MADDR;
               OP_LUI:                    next_state = S_LUI;
               OP_J:                      next_state = S_JUMP;
               OP_JAL:                    next_state = S_JAL;
               default: begin
                  next_state = S_EXC;
                  next_cause = CAUSE_OPCODE;
               end
            endcase
         end
         S_RX: begin
            if (overflow && (funct == FN_ADD || funct == FN_SUB)) begin
               next_state = S_EXC;
               next_cause = CAUSE_OVERFLOW;
            end else begin
               next_state = S_WBR;
            end
         end
         S_WBR:    next_state = S_FETCH;
         S_ADDI: begin
            if (overflow) begin
               next_state = S_EXC;
               next_cause = CAUSE_OVERFLOW;
            end else begin
               next_state = S_WBI;
            end
         end
         S_WBI:    next_state = S_FETCH;
         S_BRANCH: next_state = S_FETCH;
         S_MADDR:  next_state = (opcode == OP_LW) ? S_MRD : S_MWR;
         S_MRD:    next_state = S_MWAIT;
         S_MWAIT:  if (wait_cnt == 2'd0) next_state = S_WBL;
         S_WBL:    next_state = S_FETCH;
         S_MWR:    next_state = S_FETCH;
         S_LUI:    next_state = S_FETCH;
         S_JUMP:   next_state = S_FETCH;
         S_JAL:    next_state = S_JUMP;
         S_JR:     next_state = S_FETCH;
         S_EXC:    next_state = S_EWAIT;
         S_EWAIT:  if (wait_cnt == 2'd0) next_state = S_ELD;
         S_ELD:    next_state = S_FETCH;
         default:  next_state = S_RESET;
      endcase
   end

   // The wait counter reloads on every fresh entry into a wait state.
   assign entering_wait = (next_state == S_FWAIT || next_state == S_MWAIT ||
                           next_state == S_EWAIT) && (next_state != cur_state);

   // State, wait counter, cause and the registered control word for the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_state     <= S_RESET;
         wait_cnt      <= 2'd0;
         cause         <= 2'd0;
         pc_w_q        <= 1'b0;
         pc_src        <= 2'd0;
         crtl_error    <= 2'd0;
         crtl_iord     <= 2'd0;
         crtl_ss       <= 2'd0;
         crtl_mem_w    <= 1'b0;
         crtl_irwrite  <= 1'b0;
         crtl_regdst   <= 3'd0;
         crtl_memtoreg <= 4'd0;
         reg_w         <= 1'b0;
         ab_w          <= 1'b0;
         aluout_w      <= 1'b0;
         alu_src_a     <= 1'b0;
         alu_src_b     <= 2'd0;
         alu_op        <= 3'd0;
         epc_w         <= 1'b0;
      end else begin
         cur_state <= next_state;
         cause     <= next_cause;
         if (entering_wait) begin
            wait_cnt <= WAIT_LOAD;
         end else if (wait_cnt != 2'd0) begin
            wait_cnt <= wait_cnt - 2'd1;
         end

         pc_w_q        <= 1'b0;
         pc_src        <= 2'd0;
         crtl_error    <= 2'd0;
         crtl_iord     <= 2'd0;
         crtl_ss       <= 2'd0;
         crtl_mem_w    <= 1'b0;
         crtl_irwrite  <= 1'b0;
         crtl_regdst   <= 3'd0;
         crtl_memtoreg <= 4'd0;
         reg_w         <= 1'b0;
         ab_w          <= 1'b0;
         aluout_w      <= 1'b0;
         alu_src_a     <= 1'b0;
         alu_src_b     <= 2'd0;
         alu_op        <= 3'd0;
         epc_w         <= 1'b0;

         case (next_state)
            S_FETCH: begin
               alu_src_b <= 2'd1;
               alu_op    <= ALU_ADD;
               pc_w_q    <= 1'b1;
            end
            S_IRLD: crtl_irwrite <= 1'b1;
            S_DECODE: begin
               ab_w      <= 1'b1;
               aluout_w  <= 1'b1;
               alu_src_b <= 2'd3;
               alu_op    <= ALU_ADD;
            end
            S_RX: begin
               alu_src_a <= 1'b1;
               aluout_w  <= 1'b1;
               if (funct == FN_SUB) begin
                  alu_op <= ALU_SUB;
               end else if (funct == FN_AND) begin
                  alu_op <= ALU_AND;
               end else begin
                  alu_op <= ALU_ADD;
               end
            end
            S_WBR: begin
               reg_w         <= 1'b1;
               crtl_regdst   <= 3'd1;
               crtl_memtoreg <= 4'd1;
            end
            S_ADDI, S_MADDR: begin
               alu_src_a <= 1'b1;
               alu_src_b <= 2'd2;
               alu_op    <= ALU_ADD;
               aluout_w  <= 1'b1;
            end
            S_WBI: begin
               reg_w         <= 1'b1;
               crtl_memtoreg <= 4'd1;
            end
            S_BRANCH: begin
               alu_src_a <= 1'b1;
               alu_op    <= ALU_SUB;
               pc_src    <= 2'd1;
            end
            S_MRD, S_MWAIT: crtl_iord <= 2'd2;
            S_WBL: begin
               reg_w         <= 1'b1;
               crtl_memtoreg <= 4'd9;
            end
            S_MWR: begin
               crtl_iord  <= 2'd2;
               crtl_mem_w <= 1'b1;
               if (opcode == OP_SH) begin
                  crtl_ss <= 2'd1;
               end else if (opcode == OP_SB) begin
                  crtl_ss <= 2'd2;
               end else begin
                  crtl_ss <= 2'd0;
               end
            end
            S_LUI: begin
               reg_w         <= 1'b1;
               crtl_memtoreg <= 4'd5;
            end
            S_JUMP: begin
               pc_w_q <= 1'b1;
               pc_src <= 2'd2;
            end
            S_JAL: begin
               reg_w         <= 1'b1;
               crtl_regdst   <= 3'd2;
               crtl_memtoreg <= 4'd8;
            end
            S_JR: begin
               alu_src_a <= 1'b1;
               alu_op    <= ALU_PASS;
               pc_w_q    <= 1'b1;
            end
            S_EXC: begin
               epc_w      <= 1'b1;
               alu_src_b  <= 2'd1;
               alu_op     <= ALU_SUB;
               crtl_iord  <= 2'd1;
               crtl_error <= next_cause;
            end
            S_EWAIT: begin
               crtl_iord  <= 2'd1;
               crtl_error <= next_cause;
            end
            S_ELD: begin
               pc_w_q     <= 1'b1;
               pc_src     <= 2'd3;
               crtl_error <= next_cause;
            end
            default: begin
               pc_w_q <= 1'b0;
            end
         endcase
      end
   end

   // Branch decision follows the zero flag in the same cycle the ALU compares.
   always_comb begin
      branch_taken = 1'b0;
      if (cur_state == S_BRANCH) begin
         branch_taken = (opcode == OP_BNE) ? !zero : zero;
      end
   end

   assign PC_w  = pc_w_q | branch_taken;
   assign state = cur_state;

endmodule
